vrf_port_arbiter: RTL and testbench

//   Shares the single-port vector register file RAM (1-cycle read latency) between NumReq

---
 rtl/vrf_arb_pkg.sv | 14 +
 rtl/vrf_rr_picker.sv | 38 +++
 rtl/vrf_port_arbiter.sv | 137 +++++++++++++
 tb/tb_vrf_port_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vrf_arb_pkg.sv
// Shared types and helpers for the VRF port arbiter.
package vrf_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } vrf_arb_state_t;

    // Wrapping increment of a requester index in the range 0..n-1.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/vrf_rr_picker.sv
// Combinational round-robin pick: first valid requester at or after ptr_i, wrapping
// from NumReq-1 back to 0.
module vrf_rr_picker #(
    parameter int unsigned NumReq = 3,
    parameter int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] valid_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   gnt_idx_o
);

    logic          found;
    logic [IdxW:0] sum;
    logic [IdxW-1:0] idx;

    // One extra bit on sum so ptr + offset never overflows before the wrap.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < int'(NumReq); k++) begin
            sum = {1'b0, ptr_i} + (IdxW+1)'(k);
            if (sum >= (IdxW+1)'(NumReq)) begin
                sum = sum - (IdxW+1)'(NumReq);
            end
            idx = sum[IdxW-1:0];
            if (!found && valid_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/vrf_port_arbiter.sv
// Shares the single-port VRF RAM between NumReq requesters with locked bursts and
// routed read responses. Define VRF_ARB_WB_PRIO_EN to give the writeback port priority.
module vrf_port_arbiter
    import vrf_arb_pkg::*;
#(
    parameter int unsigned NumReq    = 3,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned AddrWidth = 5
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic [NumReq-1:0]             req_last_i,
    input  logic [NumReq-1:0]             req_we_i,
    input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
    input  logic [NumReq*DataWidth-1:0]   req_wdata_i,
    output logic [NumReq-1:0]             rsp_valid_o,
    output logic [DataWidth-1:0]          rsp_rdata_o,
    output logic                          ram_req_o,
    output logic                          ram_we_o,
    output logic [AddrWidth-1:0]          ram_addr_o,
    output logic [DataWidth-1:0]          ram_wdata_o,
    input  logic [DataWidth-1:0]          ram_rdata_i,
    output logic                          busy_o
);

    localparam int unsigned    IdxW  = $clog2(NumReq);
    localparam logic [IdxW-1:0] WbIdx = IdxW'(NumReq - 1);

    vrf_arb_state_t  state_q, state_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic            rsp_pend_q, rsp_pend_d;
    logic [IdxW-1:0] rsp_idx_q, rsp_idx_d;

    logic [AddrWidth-1:0] addr_arr  [NumReq];
    logic [DataWidth-1:0] wdata_arr [NumReq];
    logic [NumReq-1:0]    rr_gnt;
    logic [IdxW-1:0]      rr_idx;
    logic [NumReq-1:0]    gnt_vec;
    logic [IdxW-1:0]      gnt_idx;
    logic                 fire;

    for (genvar i = 0; i < int'(NumReq); i++) begin : g_unpack
        assign addr_arr[i]  = req_addr_i[i*AddrWidth +: AddrWidth];
        assign wdata_arr[i] = req_wdata_i[i*DataWidth +: DataWidth];
    end

    vrf_rr_picker #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_picker (
        .valid_i   (req_valid_i),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (rr_gnt),
        .gnt_idx_o (rr_idx)
    );

    // Grant is combinational and suppressed while reset is asserted.
    always_comb begin
        gnt_vec = '0;
        gnt_idx = '0;
        if (!rst_ni) begin
            gnt_vec = '0;
        end else if (state_q == ARB_LOCK) begin
            if (req_valid_i[owner_q]) begin
                gnt_vec[owner_q] = 1'b1;
                gnt_idx          = owner_q;
            end
        end else begin
`ifdef VRF_ARB_WB_PRIO_EN
            if (req_valid_i[WbIdx]) begin
                gnt_vec[WbIdx] = 1'b1;
                gnt_idx        = WbIdx;
            end else begin
                gnt_vec = rr_gnt;
                gnt_idx = rr_idx;
            end
`else
            gnt_vec = rr_gnt;
            gnt_idx = rr_idx;
`endif
        end
    end

    assign fire        = |gnt_vec;
    assign req_ready_o = gnt_vec;
    assign ram_req_o   = fire;
    assign ram_we_o    = fire & req_we_i[gnt_idx];
    assign ram_addr_o  = fire ? addr_arr[gnt_idx]  : '0;
    assign ram_wdata_o = fire ? wdata_arr[gnt_idx] : '0;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        rsp_pend_d = fire & ~req_we_i[gnt_idx];
        rsp_idx_d  = gnt_idx;
        if (fire) begin
            if (req_last_i[gnt_idx]) begin
                state_d  = ARB_IDLE;
                rr_ptr_d = IdxW'(rr_next(32'(gnt_idx), NumReq));
`ifdef VRF_ARB_WB_PRIO_EN
                // A priority writeback beat must not disturb the fairness rotation.
                if (state_q == ARB_IDLE && gnt_idx == WbIdx) begin
                    rr_ptr_d = rr_ptr_q;
                end
`endif
            end else begin
                state_d = ARB_LOCK;
                owner_d = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            rsp_pend_q <= 1'b0;
            rsp_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            rsp_pend_q <= rsp_pend_d;
            rsp_idx_q  <= rsp_idx_d;
        end
    end

    assign rsp_valid_o = rsp_pend_q ? (NumReq'(1) << rsp_idx_q) : '0;
    assign rsp_rdata_o = rsp_pend_q ? ram_rdata_i : '0;
    assign busy_o      = (state_q == ARB_LOCK) | rsp_pend_q;

endmodule

// File: tb/tb_vrf_port_arbiter.sv
// Bench for vrf_port_arbiter: directed requester programs, a spec-level model checked
// every cycle, and literal expectations on grant order and returned data.
module tb_vrf_port_arbiter;

    localparam int NumReq    = 3;
    localparam int DataWidth = 128;
    localparam int AddrWidth = 5;
`ifdef VRF_ARB_WB_PRIO_EN
    localparam bit WbPrio = 1'b1;
`else
    localparam bit WbPrio = 1'b0;
`endif

    logic                        clk_i = 1'b0;
    logic                        rst_ni;
    logic [NumReq-1:0]           req_valid_i, req_ready_o, req_last_i, req_we_i;
    logic [NumReq*AddrWidth-1:0] req_addr_i;
    logic [NumReq*DataWidth-1:0] req_wdata_i;
    logic [NumReq-1:0]           rsp_valid_o;
    logic [DataWidth-1:0]        rsp_rdata_o, ram_wdata_o, ram_rdata_i;
    logic                        ram_req_o, ram_we_o, busy_o;
    logic [AddrWidth-1:0]        ram_addr_o;

    always #5 clk_i = ~clk_i;

    vrf_port_arbiter #(
        .NumReq(NumReq), .DataWidth(DataWidth), .AddrWidth(AddrWidth)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_last_i(req_last_i),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .busy_o(busy_o)
    );

    function automatic logic [127:0] pat(input int a);
        logic [31:0] w;
        w = 32'hC0DE_0000 | 32'(a);
        return {4{w}};
    endfunction

    // Environment RAM: single port, one-cycle read latency.
    logic [127:0] ram_mem [32];
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int a = 0; a < 32; a++) ram_mem[a] <= pat(a);
            ram_rdata_i <= '0;
        end else if (ram_req_o) begin
            if (ram_we_o) ram_mem[ram_addr_o] <= ram_wdata_o;
            else          ram_rdata_i <= ram_mem[ram_addr_o];
        end
    end

    typedef struct {
        bit           we;
        bit           last;
        logic [4:0]   addr;
        logic [127:0] wdata;
        int           gap;
    } beat_t;

    beat_t prog [NumReq][16];
    int    head [NumReq];
    int    cnt  [NumReq];
    int    gapc [NumReq];
    bit    force_all;

    bit           d_valid [NumReq];
    bit           d_we    [NumReq];
    bit           d_last  [NumReq];
    logic [4:0]   d_addr  [NumReq];
    logic [127:0] d_wdata [NumReq];

    int checks   = 0;
    int failures = 0;

    bit           m_lock, m_pend;
    int           m_owner, m_rr, m_pidx;
    logic [127:0] m_pdata;
    logic [127:0] m_mem [32];
    bit           n_lock, n_pend, n_wr;
    int           n_owner, n_rr, n_pidx, n_waddr;
    logic [127:0] n_pdata, n_wdata;

    int           glog[$];
    int           rlog_idx[$];
    logic [127:0] rlog_data[$];
    int           bubble_cnt;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int oh2idx(input logic [NumReq-1:0] oh);
        for (int i = 0; i < NumReq; i++) if (oh[i]) return i;
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < NumReq; i++) begin
            d_valid[i] = force_all || (head[i] < cnt[i] && gapc[i] == 0);
            if (head[i] < cnt[i]) begin
                d_we[i]    = prog[i][head[i]].we;
                d_last[i]  = prog[i][head[i]].last;
                d_addr[i]  = prog[i][head[i]].addr;
                d_wdata[i] = prog[i][head[i]].wdata;
            end else begin
                d_we[i] = 1'b0; d_last[i] = 1'b1; d_addr[i] = '0; d_wdata[i] = '0;
            end
            req_valid_i[i] = d_valid[i];
            req_we_i[i]    = d_we[i];
            req_last_i[i]  = d_last[i];
            req_addr_i[i*AddrWidth +: AddrWidth]  = d_addr[i];
            req_wdata_i[i*DataWidth +: DataWidth] = d_wdata[i];
        end
    endtask

    task automatic load(input int r, input bit we, input bit last, input int addr,
                        input logic [127:0] wd, input int gap);
        prog[r][cnt[r]] = '{we, last, 5'(addr), wd, gap};
        if (head[r] == cnt[r]) gapc[r] = gap;
        cnt[r]++;
    endtask

    task automatic clear_progs();
        for (int i = 0; i < NumReq; i++) begin
            head[i] = 0; cnt[i] = 0; gapc[i] = 0;
        end
    endtask

    function automatic bit pending();
        for (int i = 0; i < NumReq; i++) if (head[i] < cnt[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Spec-level expectation for the current cycle, plus the state it leads to.
    task automatic model_check();
        int eg;
        int e_ready;
        eg = -1;
        if (rst_ni) begin
            if (m_lock) begin
                if (d_valid[m_owner]) eg = m_owner;
            end else begin
                if (WbPrio && d_valid[NumReq-1]) eg = NumReq - 1;
                for (int k = 0; k < NumReq; k++)
                    if (eg < 0 && d_valid[(m_rr + k) % NumReq]) eg = (m_rr + k) % NumReq;
            end
        end
        e_ready = (eg >= 0) ? (1 << eg) : 0;
        chk("ready", req_ready_o, e_ready);
        chk("ram_req", ram_req_o, eg >= 0);
        chk("ram_we", ram_we_o, (eg >= 0) ? d_we[eg] : 1'b0);
        chk("ram_addr", ram_addr_o, (eg >= 0) ? d_addr[eg] : 5'd0);
        chk("ram_wdata", ram_wdata_o, (eg >= 0) ? d_wdata[eg] : 128'd0);
        chk("rsp_valid", rsp_valid_o, (rst_ni && m_pend) ? (1 << m_pidx) : 0);
        chk("rsp_rdata", rsp_rdata_o, (rst_ni && m_pend) ? m_pdata : 128'd0);
        chk("busy", busy_o, rst_ni && (m_lock || m_pend));

        n_lock = m_lock; n_owner = m_owner; n_rr = m_rr;
        n_pend = 1'b0; n_pidx = m_pidx; n_pdata = m_pdata; n_wr = 1'b0;
        n_waddr = 0; n_wdata = '0;
        if (eg >= 0) begin
            if (d_we[eg]) begin
                n_wr = 1'b1; n_waddr = int'(d_addr[eg]); n_wdata = d_wdata[eg];
            end else begin
                n_pend = 1'b1; n_pidx = eg; n_pdata = m_mem[d_addr[eg]];
            end
            if (d_last[eg]) begin
                if (!(WbPrio && !m_lock && eg == NumReq - 1)) n_rr = (eg + 1) % NumReq;
                n_lock = 1'b0;
            end else begin
                n_lock = 1'b1; n_owner = eg;
            end
        end
    endtask

    task automatic model_commit();
        if (!rst_ni) begin
            m_lock = 1'b0; m_pend = 1'b0; m_owner = 0; m_rr = 0; m_pidx = 0; m_pdata = '0;
            for (int a = 0; a < 32; a++) m_mem[a] = pat(a);
        end else begin
            m_lock = n_lock; m_owner = n_owner; m_rr = n_rr;
            m_pend = n_pend; m_pidx = n_pidx; m_pdata = n_pdata;
            if (n_wr) m_mem[n_waddr] = n_wdata;
        end
    endtask

    task automatic tick();
        logic [NumReq-1:0] acc;
        @(negedge clk_i);
        acc = req_ready_o & req_valid_i;
        model_check();
        if (ram_req_o) glog.push_back(oh2idx(req_ready_o));
        if (rsp_valid_o != '0) begin
            rlog_idx.push_back(oh2idx(rsp_valid_o));
            rlog_data.push_back(rsp_rdata_o);
        end
        if (rst_ni && busy_o && !ram_req_o && req_valid_i[2] && !req_ready_o[2] && !req_valid_i[0])
            bubble_cnt++;
        @(posedge clk_i);
        model_commit();
        #1;
        for (int i = 0; i < NumReq; i++) begin
            if (acc[i]) begin
                head[i]++;
                if (head[i] < cnt[i]) gapc[i] = prog[i][head[i]].gap;
            end else if (head[i] < cnt[i] && gapc[i] > 0) begin
                gapc[i]--;
            end
        end
        drive();
    endtask

    task automatic run_idle(input int max);
        int n;
        n = 0;
        while ((pending() || busy_o) && n < max) begin
            tick();
            n++;
        end
        chk("drain_timeout", n >= max, 1'b0);
    endtask

    task automatic clear_logs();
        glog.delete(); rlog_idx.delete(); rlog_data.delete(); bubble_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        force_all = 1'b1;
        clear_progs();
        clear_logs();
        drive();
        repeat (3) tick();
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_ram_req", ram_req_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", req_ready_o, 0);
        force_all = 1'b0;
        drive();
        tick();
        rst_ni = 1'b1;
        tick();

        // Round-robin single reads from all requesters.
        clear_logs();
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < NumReq; i++) load(i, 1'b0, 1'b1, 8 + i*4 + k, '0, 0);
        drive();
        run_idle(100);
        chk("rr_count", glog.size(), 12);
        for (int j = 0; j < 6; j++) chk("rr_order", glog[j], j % 3);
        chk("rr_rsp0_idx", rlog_idx[0], 0);
        chk("rr_rsp0_data", rlog_data[0], pat(8));
        chk("rr_rsp1_idx", rlog_idx[1], 1);
        chk("rr_rsp1_data", rlog_data[1], pat(12));
        chk("rr_rsp3_data", rlog_data[3], pat(9));

        // Locked 3-beat burst from req 0 while req 1 waits.
        clear_logs();
        load(0, 1'b0, 1'b0, 1, '0, 0);
        load(0, 1'b0, 1'b0, 2, '0, 0);
        load(0, 1'b0, 1'b1, 3, '0, 0);
        load(1, 1'b0, 1'b1, 9, '0, 0);
        drive();
        run_idle(100);
        chk("lock_g0", glog[0], 0);
        chk("lock_g1", glog[1], 0);
        chk("lock_g2", glog[2], 0);
        chk("lock_g3", glog[3], 1);
        for (int j = 0; j < 3; j++) begin
            chk("lock_rsp_idx", rlog_idx[j], 0);
            chk("lock_rsp_data", rlog_data[j], pat(j + 1));
        end
        chk("lock_rsp3_data", rlog_data[3], pat(9));

        // Owner drops valid for two cycles mid-burst.
        clear_logs();
        load(0, 1'b0, 1'b0, 4, '0, 0);
        load(0, 1'b0, 1'b0, 5, '0, 2);
        load(0, 1'b0, 1'b1, 6, '0, 0);
        load(2, 1'b0, 1'b1, 12, '0, 1);
        drive();
        run_idle(100);
        chk("bubble_cycles", bubble_cnt, 2);
        chk("bubble_order", glog.size() == 4 && glog[3] == 2, 1'b1);
        chk("bubble_data", rlog_data[1], pat(5));

        // Write via writeback port, then read back via req 1.
        clear_logs();
        load(2, 1'b1, 1'b1, 7, {16{8'hA5}}, 0);
        load(1, 1'b0, 1'b1, 7, '0, 1);
        drive();
        run_idle(100);
        chk("wr_rsp_count", rlog_idx.size(), 1);
        chk("wr_rsp_idx", rlog_idx[0], 1);
        chk("wr_rsp_data", rlog_data[0], {16{8'hA5}});

        // Reset in the middle of a burst with a read response pending.
        clear_logs();
        load(0, 1'b0, 1'b0, 1, '0, 0);
        load(0, 1'b0, 1'b0, 2, '0, 0);
        load(0, 1'b0, 1'b1, 3, '0, 0);
        drive();
        tick();
        tick();
        chk("midrst_busy_before", busy_o, 1'b1);
        rst_ni = 1'b0;
        clear_progs();
        drive();
        #1;
        chk("midrst_rsp_valid", rsp_valid_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_ram_req", ram_req_o, 0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // rr_ptr = 0 with req 0 and the writeback port both valid.
        clear_logs();
        load(0, 1'b0, 1'b1, 21, '0, 0);
        load(2, 1'b0, 1'b1, 22, '0, 0);
        drive();
        run_idle(100);
        chk("prio_first", glog[0], WbPrio ? 2 : 0);
        chk("prio_second", glog[1], WbPrio ? 0 : 2);
        chk("prio_data", rlog_data[0], WbPrio ? pat(22) : pat(21));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
